// File: rtl/ibutt2_if.sv
// Handshake bundle for the radix-2 inverse butterfly: input side (y0/y1/W) and output side (x0/x1).
// Complex words are {re[31:16], im[15:0]}, each signed Q4.11.
interface ibutt2_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0;
  logic [31:0] y1;
  logic [31:0] W;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x0;
  logic [31:0] x1;

  modport master (
    output in_valid, y0, y1, W, out_ready,
    input  in_ready, out_valid, x0, x1
  );

  modport slave (
    input  in_valid, y0, y1, W, out_ready,
    output in_ready, out_valid, x0, x1
  );
endinterface

// File: rtl/ibutt2_pipe.sv
// Three-stage pipelined radix-2 inverse butterfly: x0 = y0+y1, x1 = conj(W)*(y0-y1), global stall.
// Optional 1/2 scaling in the add/sub stage is enabled by defining IBUTT2_SCALE_EN.
module ibutt2_pipe (
  input  logic    clk,
  input  logic    rst,
  ibutt2_if.slave bus
);

`ifdef IBUTT2_SCALE_EN
  localparam int unsigned SCALE_SH = 1;
`else
  localparam int unsigned SCALE_SH = 0;
`endif

  // Sign-magnitude Q4.11 multiply: truncation toward zero, then the sign is reapplied.
  function automatic logic [15:0] q11_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic [31:0] mag_p;
    logic [15:0] kept;
    mag_a = a[15] ? 16'(~a + 16'd1) : a;
    mag_b = b[15] ? 16'(~b + 16'd1) : b;
    mag_p = 32'(mag_a) * 32'(mag_b);
    kept  = 16'(mag_p >> 11);
    return (a[15] ^ b[15]) ? 16'(~kept + 16'd1) : kept;
  endfunction

  logic        adv;

  logic [16:0] sum_re;
  logic [16:0] sum_im;
  logic [16:0] dif_re;
  logic [16:0] dif_im;
  logic [15:0] s_re_n;
  logic [15:0] s_im_n;
  logic [15:0] d_re_n;
  logic [15:0] d_im_n;

  logic        v1;
  logic [15:0] s1_re;
  logic [15:0] s1_im;
  logic [15:0] d1_re;
  logic [15:0] d1_im;
  logic [15:0] w1_re;
  logic [15:0] w1_im;

  logic [15:0] p_rr_n;
  logic [15:0] p_ii_n;
  logic [15:0] p_ir_n;
  logic [15:0] p_ri_n;

  logic        v2;
  logic [15:0] s2_re;
  logic [15:0] s2_im;
  logic [15:0] p_rr;
  logic [15:0] p_ii;
  logic [15:0] p_ir;
  logic [15:0] p_ri;

  logic [15:0] x1_re_n;
  logic [15:0] x1_im_n;

  logic        v3;
  logic [31:0] x0_q;
  logic [31:0] x1_q;

  assign adv          = !v3 || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3;
  assign bus.x0       = x0_q;
  assign bus.x1       = x1_q;

  // 17-bit sign-extended add/sub so the optional halving sees the true sum.
  assign sum_re = {bus.y0[31], bus.y0[31:16]} + {bus.y1[31], bus.y1[31:16]};
  assign sum_im = {bus.y0[15], bus.y0[15:0]}  + {bus.y1[15], bus.y1[15:0]};
  assign dif_re = {bus.y0[31], bus.y0[31:16]} - {bus.y1[31], bus.y1[31:16]};
  assign dif_im = {bus.y0[15], bus.y0[15:0]}  - {bus.y1[15], bus.y1[15:0]};

  assign s_re_n = 16'(sum_re >> SCALE_SH);
  assign s_im_n = 16'(sum_im >> SCALE_SH);
  assign d_re_n = 16'(dif_re >> SCALE_SH);
  assign d_im_n = 16'(dif_im >> SCALE_SH);

  assign p_rr_n = q11_mul(d1_re, w1_re);
  assign p_ii_n = q11_mul(d1_im, w1_im);
  assign p_ir_n = q11_mul(d1_im, w1_re);
  assign p_ri_n = q11_mul(d1_re, w1_im);

  // conj(W): the imaginary twiddle terms enter with flipped sign.
  assign x1_re_n = p_rr + p_ii;
  assign x1_im_n = p_ir - p_ri;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      s1_re <= '0;
      s1_im <= '0;
      d1_re <= '0;
      d1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
      v2    <= 1'b0;
      s2_re <= '0;
      s2_im <= '0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ir  <= '0;
      p_ri  <= '0;
      v3    <= 1'b0;
      x0_q  <= '0;
      x1_q  <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      if (bus.in_valid) begin
        s1_re <= s_re_n;
        s1_im <= s_im_n;
        d1_re <= d_re_n;
        d1_im <= d_im_n;
        w1_re <= bus.W[31:16];
        w1_im <= bus.W[15:0];
      end
      if (v1) begin
        s2_re <= s1_re;
        s2_im <= s1_im;
        p_rr  <= p_rr_n;
        p_ii  <= p_ii_n;
        p_ir  <= p_ir_n;
        p_ri  <= p_ri_n;
      end
      if (v2) begin
        x0_q <= {s2_re, s2_im};
        x1_q <= {x1_re_n, x1_im_n};
      end
    end
  end

endmodule

// File: tb/tb_ibutt2_pipe.sv
// Bench for ibutt2_pipe: arithmetic reference model + scoreboard, plus literal vectors.
// Define IBUTT2_SCALE_EN for both bench and RTL to exercise the scaled build.
module tb_ibutt2_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibutt2_if bus ();

  ibutt2_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef IBUTT2_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the butterfly definition.
  function automatic int q11_prod(input int a, input int b);
    int p;
    int m;
    p = a * b;
    m = (p < 0) ? -p : p;
    m = (m / 2048) % 65536;
    return (p < 0) ? -m : m;
  endfunction

  function automatic logic [63:0] ref_bfly(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] w);
    int sr, si, dr, di, wr, wi;
    logic [15:0] x0r, x0i, x1r, x1i;
    sr = int'($signed(a[31:16])) + int'($signed(b[31:16]));
    si = int'($signed(a[15:0]))  + int'($signed(b[15:0]));
    dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
    di = int'($signed(a[15:0]))  - int'($signed(b[15:0]));
    if (SCALE) begin
      sr = sr >>> 1;
      si = si >>> 1;
      dr = dr >>> 1;
      di = di >>> 1;
    end
    dr = int'($signed(16'(dr)));
    di = int'($signed(16'(di)));
    wr = int'($signed(w[31:16]));
    wi = int'($signed(w[15:0]));
    x0r = 16'(sr);
    x0i = 16'(si);
    x1r = 16'(q11_prod(dr, wr) + q11_prod(di, wi));
    x1i = 16'(q11_prod(di, wr) - q11_prod(dr, wi));
    return {x0r, x0i, x1r, x1i};
  endfunction

  // Compare process: inputs/out_ready change just after posedge, so negedge sees the
  // values that decide the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid), 64'(0));
        end else begin
          chk("sb_data", {bus.x0, bus.x1}, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_bfly(bus.y0, bus.y1, bus.W));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One item, no stall: valid after the accepting edge plus two more edges.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] w, input logic [31:0] e0, input logic [31:0] e1);
    bus.out_ready = 1'b1;
    bus.y0 = a;
    bus.y1 = b;
    bus.W  = w;
    bus.in_valid = 1'b1;
    #1;
    chk({name, "_rdy"}, 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    chk({name, "_lat1"}, 64'(bus.out_valid), 64'(0));
    tick();
    chk({name, "_lat2"}, 64'(bus.out_valid), 64'(0));
    tick();
    chk({name, "_lat3"}, 64'(bus.out_valid), 64'(1));
    chk({name, "_x"}, {bus.x0, bus.x1}, {e0, e1});
    tick();
  endtask

  function automatic logic [31:0] wsel(input int c);
    case (c % 4)
      0:       return 32'h0800_0000;
      1:       return 32'h0000_F800;
      2:       return 32'h05A8_05A8;
      default: return 32'h8000_7FFF;
    endcase
  endfunction

  function automatic logic [31:0] tag_x0(input int k);
    return SCALE ? {16'(k), 16'h0000} : {16'(2 * k), 16'h0000};
  endfunction

  int idx;
  int ncyc;
  logic [31:0] got[$];

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.y0 = '0;
    bus.y1 = '0;
    bus.W  = '0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_x", {bus.x0, bus.x1}, 64'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    if (SCALE) begin
      run_one("unit_w",  32'h1000_0000, 32'h0800_0000, 32'h0800_0000, 32'h0C00_0000, 32'h0400_0000);
      run_one("minus_j", 32'h0800_0000, 32'h0000_0000, 32'h0000_F800, 32'h0400_0000, 32'h0000_0400);
      run_one("cplx",    32'h0400_0200, 32'h0100_0100, 32'h0800_0800, 32'h0280_0180, 32'h0200_FF00);
      run_one("trunc_p", 32'h0001_0000, 32'h0000_0000, 32'h0400_0000, 32'h0000_0000, 32'h0000_0000);
      run_one("trunc_n", 32'hFFFF_0000, 32'h0000_0000, 32'h0400_0000, 32'hFFFF_0000, 32'h0000_0000);
      run_one("max_in",  32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h0800_0000, 32'h7FFF_7FFF, 32'h0000_0000);
      run_one("w_min",   32'h0010_0000, 32'h0000_0000, 32'h8000_0000, 32'h0008_0000, 32'hFF80_0000);
    end else begin
      run_one("unit_w",  32'h1000_0000, 32'h0800_0000, 32'h0800_0000, 32'h1800_0000, 32'h0800_0000);
      run_one("minus_j", 32'h0800_0000, 32'h0000_0000, 32'h0000_F800, 32'h0800_0000, 32'h0000_0800);
      run_one("cplx",    32'h0400_0200, 32'h0100_0100, 32'h0800_0800, 32'h0500_0300, 32'h0400_FE00);
      run_one("trunc_p", 32'h0001_0000, 32'h0000_0000, 32'h0400_0000, 32'h0001_0000, 32'h0000_0000);
      run_one("trunc_n", 32'hFFFF_0000, 32'h0000_0000, 32'h0400_0000, 32'hFFFF_0000, 32'h0000_0000);
      run_one("max_in",  32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h0800_0000, 32'hFFFE_FFFE, 32'h0000_0000);
      run_one("w_min",   32'h0010_0000, 32'h0000_0000, 32'h8000_0000, 32'h0010_0000, 32'hFF00_0000);
    end

    // Back-pressure: five tagged items against a stalled sink.
    idx = 0;
    bus.out_ready = 1'b0;
    bus.W = 32'h0800_0000;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (idx < 5);
      bus.y0 = {16'(idx + 1), 16'h0000};
      bus.y1 = bus.y0;
      #1;
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    chk("stall_accepted", 64'(idx), 64'(3));
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    chk("stall_x0_held", 64'(bus.x0), 64'(tag_x0(1)));

    bus.out_ready = 1'b1;
    ncyc = 0;
    got.delete();
    while (got.size() < 5 && ncyc < 20) begin
      bus.in_valid = (idx < 5);
      bus.y0 = {16'(idx + 1), 16'h0000};
      bus.y1 = bus.y0;
      #1;
      if (bus.out_valid) got.push_back(bus.x0);
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
      ncyc++;
    end
    bus.in_valid = 1'b0;
    chk("release_count", 64'(got.size()), 64'(5));
    chk("release_cycles", 64'(ncyc), 64'(5));
    for (int k = 0; k < got.size(); k++) chk("release_order", 64'(got[k]), 64'(tag_x0(k + 1)));
    repeat (4) tick();

    // Reset with two items in flight.
    bus.out_ready = 1'b1;
    bus.W  = 32'h0800_0000;
    bus.y1 = '0;
    bus.y0 = 32'h1234_0000;
    bus.in_valid = 1'b1;
    tick();
    bus.y0 = 32'h2345_0000;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_x", {bus.x0, bus.x1}, 64'(0));
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_discard", 64'(bus.out_valid), 64'(0));
    end
    if (SCALE)
      run_one("after_rst", 32'h0200_0000, 32'h0000_0000, 32'h0800_0000, 32'h0100_0000, 32'h0100_0000);
    else
      run_one("after_rst", 32'h0200_0000, 32'h0000_0000, 32'h0800_0000, 32'h0200_0000, 32'h0200_0000);

    // Mixed valid/ready pattern; the scoreboard checks every output cycle.
    for (int c = 0; c < 40; c++) begin
      bus.in_valid  = (c % 3) != 1;
      bus.out_ready = ((c % 5) != 2) && ((c % 7) != 3);
      bus.y0 = {16'(c * 2311 - 30000), 16'(c * 977 + 12345)};
      bus.y1 = {16'(20000 - c * 1500), 16'(c * 4099)};
      bus.W  = wsel(c);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_idle", 64'(bus.out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
